// File: rtl/ser_ctrl_master_pkg.sv
// Shared chain definitions (payload/command widths, command codes) and the
// master-side operation and state types used by serial_ctrl_master.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif
`ifndef CMD_LEN
`define CMD_LEN 3
`endif

package ser_ctrl_master_pkg;

  localparam int DATA_LEN_DEF = `DATA_LEN;
  localparam int CMD_LEN_DEF  = `CMD_LEN;

  typedef logic [`CMD_LEN-1:0] ctrl_cmd_t;

  localparam ctrl_cmd_t RESET_CMD     = ctrl_cmd_t'(5);
  localparam ctrl_cmd_t START_RCV_CMD = ctrl_cmd_t'(6);
  localparam ctrl_cmd_t UPDATE_CMD    = ctrl_cmd_t'(3);
  localparam ctrl_cmd_t START_SND_CMD = ctrl_cmd_t'(4);

  localparam int RST_GAP_DEF = 3;
  localparam int RCV_GAP_DEF = 1;
  localparam int UPD_GAP_DEF = 3;
  localparam int SND_GAP_DEF = 2;

  typedef enum logic [1:0] {
    OP_RESET  = 2'd0,
    OP_WRITE  = 2'd1,
    OP_UPDATE = 2'd2,
    OP_READ   = 2'd3
  } master_op_t;

  typedef enum logic [3:0] {
    IDLE, START, CMD, CMD_TAIL, GAP, WDATA, WTAIL, RDATA, RTURN, DONE
  } mst_state_t;

  function automatic ctrl_cmd_t op_to_cmd(input master_op_t op);
    ctrl_cmd_t c;
    case (op)
      OP_RESET:  c = RESET_CMD;
      OP_WRITE:  c = START_RCV_CMD;
      OP_UPDATE: c = UPDATE_CMD;
      default:   c = START_SND_CMD;
    endcase
    return c;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load, MSB-first shift register with serial in/out; load wins over shift.
module ser_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic         ser_o,
  output logic [W-1:0] par_o
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = load_val_i;
    end else if (shift_i) begin
      sh_d = {sh_q[W-2:0], ser_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign ser_o = sh_q[W-1];
  assign par_o = sh_q;

endmodule

// File: rtl/serial_ctrl_master.sv
// Initiator of the single-wire daisychain control protocol: serialises one host
// operation per request and, for READ, releases the line and captures the reply.
module serial_ctrl_master
  import ser_ctrl_master_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int CMD_LEN  = CMD_LEN_DEF,
  parameter int RST_GAP  = RST_GAP_DEF,
  parameter int RCV_GAP  = RCV_GAP_DEF,
  parameter int UPD_GAP  = UPD_GAP_DEF,
  parameter int SND_GAP  = SND_GAP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  master_op_t          req_op,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                rsp_valid,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                busy,
  output logic                bus_oe,
  inout  wire                 data_inout
);

  localparam int GAP_MAX = max2(max2(RST_GAP, RCV_GAP), max2(UPD_GAP, SND_GAP));
  localparam int CNT_MAX = max2(max2(DATA_LEN, CMD_LEN), GAP_MAX);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = max2(DATA_LEN, CMD_LEN);

  mst_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  master_op_t          op_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic                line_q;
  logic                oe_q;
  logic                ready_q;
  logic                busy_q;
  logic                rsp_valid_q;
  logic [DATA_LEN-1:0] rsp_data_q;

  logic          accept;
  logic          go_post;
  logic [CW-1:0] gap_sel;
  logic          sh_load;
  logic          sh_shift;
  logic [SW-1:0] sh_load_val;
  logic          sh_msb;
  logic [SW-1:0] sh_par;

  assign accept = req_valid && ready_q;

  always_comb begin
    gap_sel = '0;
    case (op_q)
      OP_RESET:  gap_sel = CW'(RST_GAP);
      OP_WRITE:  gap_sel = CW'(RCV_GAP);
      OP_UPDATE: gap_sel = CW'(UPD_GAP);
      default:   gap_sel = CW'(SND_GAP);
    endcase
  end

  // Leaving the command tail (no gap) or the last gap cycle enters the op body.
  assign go_post = ((state_q == CMD_TAIL) && (gap_sel == '0)) ||
                   ((state_q == GAP) && (cnt_q == '0));

  // One shifter serves all phases: command loads at acceptance, write data
  // loads once the last command bit has left, read data shifts in at the LSB.
  always_comb begin
    sh_load     = accept || ((state_q == CMD) && (cnt_q == '0));
    sh_load_val = SW'(wdata_q) << (SW - DATA_LEN);
    if (accept) begin
      sh_load_val = SW'(op_to_cmd(req_op)) << (SW - CMD_LEN);
    end
    sh_shift = (state_q == START) ||
               ((state_q == CMD) && (cnt_q != '0)) ||
               (go_post && (op_q == OP_WRITE)) ||
               ((state_q == WDATA) && (cnt_q != '0)) ||
               (state_q == RDATA);
  end

  ser_shift_reg #(
    .W(SW)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (sh_load),
    .load_val_i(sh_load_val),
    .shift_i   (sh_shift),
    .ser_i     (data_inout),
    .ser_o     (sh_msb),
    .par_o     (sh_par)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_RESET;
      wdata_q     <= '0;
      line_q      <= 1'b0;
      oe_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= START;
            op_q    <= req_op;
            wdata_q <= req_data;
            line_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          state_q <= CMD;
          cnt_q   <= CW'(CMD_LEN - 1);
          line_q  <= sh_msb;
        end
        CMD: begin
          if (cnt_q == '0) begin
            state_q <= CMD_TAIL;
            line_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            line_q <= sh_msb;
          end
        end
        CMD_TAIL: begin
          if (gap_sel != '0) begin
            state_q <= GAP;
            cnt_q   <= gap_sel - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WDATA: begin
          if (cnt_q == '0) begin
            state_q <= WTAIL;
            line_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            line_q <= sh_msb;
          end
        end
        WTAIL: begin
          state_q <= DONE;
        end
        RDATA: begin
          if (cnt_q == '0) begin
            state_q <= RTURN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RTURN: begin
          state_q     <= DONE;
          oe_q        <= 1'b1;
          line_q      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= sh_par[DATA_LEN-1:0];
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (go_post) begin
        case (op_q)
          OP_WRITE: begin
            state_q <= WDATA;
            cnt_q   <= CW'(DATA_LEN - 1);
            line_q  <= sh_msb;
          end
          OP_READ: begin
            state_q <= RDATA;
            cnt_q   <= CW'(DATA_LEN - 1);
            oe_q    <= 1'b0;
            line_q  <= 1'b0;
          end
          default: begin
            state_q <= DONE;
            line_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign bus_oe     = oe_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign data_inout = oe_q ? line_q : 1'bz;

endmodule

// File: tb/tb_serial_ctrl_master.sv
// Directed and randomised bench for serial_ctrl_master with a frame-level
// reference model and a simple slave that answers READ frames.
module tb_serial_ctrl_master;
  import ser_ctrl_master_pkg::*;

  localparam int DL = DATA_LEN_DEF;
  localparam int CL = CMD_LEN_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  master_op_t    req_op = OP_RESET;
  logic [DL-1:0] req_data = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DL-1:0] rsp_data;
  logic          busy;
  logic          bus_oe;
  wire           data_inout;

  logic          slave_bit = 1'b0;
  logic [DL-1:0] slave_word = '0;
  int            slave_k = 0;

  int checks = 0;
  int failures = 0;

  logic [DL-1:0] last_rsp = '0;
  bit exp_oe[$];
  bit exp_ln[$];

  serial_ctrl_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .bus_oe    (bus_oe),
    .data_inout(data_inout)
  );

  always #5 clk = ~clk;

  // Slave side: drives its word MSB first while the master has released the line.
  assign data_inout = bus_oe ? 1'bz : slave_bit;

  always @(negedge clk) begin
    if (bus_oe) begin
      slave_k   = 0;
      slave_bit = 1'b0;
    end else begin
      slave_bit = (slave_k < DL) ? slave_word[DL-1-slave_k] : 1'b0;
      slave_k++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_cmd_t cmd_of(input master_op_t op);
    case (op)
      OP_RESET:  return RESET_CMD;
      OP_WRITE:  return START_RCV_CMD;
      OP_UPDATE: return UPDATE_CMD;
      default:   return START_SND_CMD;
    endcase
  endfunction

  function automatic int gap_of(input master_op_t op);
    case (op)
      OP_RESET:  return 3;
      OP_WRITE:  return 1;
      OP_UPDATE: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected per-cycle (bus_oe, line) sequence from acceptance to the DONE cycle.
  task automatic build_trace(input master_op_t op, input logic [DL-1:0] data);
    ctrl_cmd_t c;
    c = cmd_of(op);
    exp_oe.delete();
    exp_ln.delete();
    exp_oe.push_back(1'b1); exp_ln.push_back(1'b1);
    for (int i = CL - 1; i >= 0; i--) begin
      exp_oe.push_back(1'b1); exp_ln.push_back(c[i]);
    end
    exp_oe.push_back(1'b1); exp_ln.push_back(1'b0);
    for (int g = 0; g < gap_of(op); g++) begin
      exp_oe.push_back(1'b1); exp_ln.push_back(1'b0);
    end
    if (op == OP_WRITE) begin
      for (int i = DL - 1; i >= 0; i--) begin
        exp_oe.push_back(1'b1); exp_ln.push_back(data[i]);
      end
      exp_oe.push_back(1'b1); exp_ln.push_back(1'b0);
    end else if (op == OP_READ) begin
      for (int i = 0; i < DL + 1; i++) begin
        exp_oe.push_back(1'b0); exp_ln.push_back(1'b0);
      end
    end
    exp_oe.push_back(1'b1); exp_ln.push_back(1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_oe"}, bus_oe, 1);
    chk({tag, "_line"}, data_inout, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, last_rsp);
  endtask

  // Called just after a negedge with the DUT idle; returns just after the
  // negedge of the first idle cycle following the operation.
  task automatic run_op(input master_op_t op, input logic [DL-1:0] data,
                        input logic [DL-1:0] rd_word, input bit hold,
                        input master_op_t nxt_op, input logic [DL-1:0] nxt_data);
    int n;
    int fails0;
    bit last;
    fails0 = failures;
    slave_word = rd_word;
    req_valid = 1'b1;
    req_op = op;
    req_data = data;
    chk("ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1;
    if (hold) begin
      req_op = nxt_op;
      req_data = nxt_data;
    end else begin
      req_valid = 1'($urandom_range(0, 1));
      req_op = master_op_t'(2'($urandom_range(0, 3)));
      req_data = DL'($urandom);
    end
    build_trace(op, data);
    n = exp_oe.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      last = (i == n - 1);
      chk("busy", busy, 1);
      chk("ready", req_ready, 0);
      chk($sformatf("bus_oe[%0d]", i), bus_oe, exp_oe[i]);
      if (exp_oe[i]) chk($sformatf("line[%0d]", i), data_inout, exp_ln[i]);
      else chk("line_known", $isunknown(data_inout), 0);
      chk("rsp_valid", rsp_valid, (op == OP_READ) && last);
      chk("rsp_data", rsp_data, ((op == OP_READ) && last) ? rd_word : last_rsp);
    end
    if (op == OP_READ) last_rsp = rd_word;
    @(negedge clk);
    chk_idle("after_op");
    if (!hold) req_valid = 1'b0;
    $display("op=%s data=%h rd=%h cycles=%0d rsp=%h result=%s",
             op.name(), data, rd_word, n, rsp_data, (failures == fails0) ? "ok" : "bad");
  endtask

  initial begin
    master_op_t rop;
    logic [DL-1:0] rdat;
    logic [DL-1:0] rword;

    // Reset held for two edges.
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    $display("reset released: ready=%b busy=%b oe=%b rsp_data=%h", req_ready, busy, bus_oe, rsp_data);

    run_op(OP_RESET, '0, '0, 1'b0, OP_RESET, '0);
    run_op(OP_WRITE, 8'h48, '0, 1'b0, OP_RESET, '0);
    run_op(OP_UPDATE, '0, '0, 1'b0, OP_RESET, '0);
    run_op(OP_READ, '0, 8'h48, 1'b0, OP_RESET, '0);

    for (int t = 0; t < 12; t++) begin
      rop = master_op_t'(2'($urandom_range(0, 3)));
      rdat = DL'($urandom);
      rword = DL'($urandom);
      run_op(rop, rdat, rword, 1'b0, OP_RESET, '0);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        @(negedge clk);
        chk_idle("idle_gap");
      end
    end

    // Reset during the write payload, after four data bits have been driven.
    req_valid = 1'b1;
    req_op = OP_WRITE;
    req_data = 8'h3C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    build_trace(OP_WRITE, 8'h3C);
    for (int i = 0; i < 1 + CL + 1 + 1 + 4; i++) begin
      @(negedge clk);
      chk($sformatf("midw_line[%0d]", i), data_inout, exp_ln[i]);
    end
    rst_n = 1'b0;
    last_rsp = '0;
    @(negedge clk);
    chk_idle("mid_write_reset");
    rst_n = 1'b1;
    $display("reset mid-write: line=%b oe=%b ready=%b busy=%b rsp_valid=%b",
             data_inout, bus_oe, req_ready, busy, rsp_valid);
    run_op(OP_RESET, '0, '0, 1'b0, OP_RESET, '0);

    // Request held valid, alternating WRITE/READ of 8'hA5.
    run_op(OP_WRITE, 8'hA5, '0, 1'b1, OP_READ, 8'hA5);
    run_op(OP_READ, 8'hA5, 8'hA5, 1'b1, OP_WRITE, 8'hA5);
    run_op(OP_WRITE, 8'hA5, '0, 1'b1, OP_READ, 8'hA5);
    run_op(OP_READ, 8'hA5, 8'hA5, 1'b0, OP_RESET, '0);
    chk("alt_read_data", rsp_data, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_ctrl_master.md
Name: serial_ctrl_master

Overview:
- Initiator end of the single-wire daisychain control protocol. It drives frames into `serial_ctrl` slaves and reads back their data.
- Takes one host operation at a time over a valid/ready request port: RESET, WRITE, UPDATE or READ.
- Serialises the operation as start bit, command and data on the bidirectional line. During READ it releases the line and deserialises the slave's reply.
- Sits between the on-chip host/register logic and the first chain element.

Parameters:
- `DATA_LEN`, default `` `DATA_LEN `` (8): payload width.
- `CMD_LEN`, default `` `CMD_LEN ``: command field width, matching `ctrl_cmd_t`.
- `RST_GAP`, default 3: idle cycles (line driven 0) after a RESET command frame.
- `RCV_GAP`, default 1: idle cycles between the START_RCV frame and the first write data bit.
- `UPD_GAP`, default 3: idle cycles after an UPDATE command frame.
- `SND_GAP`, default 2: driven-0 cycles between the START_SND frame and line release.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: host operation request.
- `req_ready` out 1: high only in IDLE. An operation is accepted when `req_valid && req_ready` at a rising edge.
- `req_op` in 2: `master_op_t`, one of OP_RESET, OP_WRITE, OP_UPDATE, OP_READ.
- `req_data` in `DATA_LEN`: write payload, captured at acceptance.
- `rsp_valid` out 1: one-cycle pulse when READ data is available.
- `rsp_data` out `DATA_LEN`: last read word; held until the next READ completes.
- `busy` out 1: high from acceptance until return to IDLE.
- `bus_oe` out 1: high when the master drives `data_inout`.
- `data_inout` inout 1: chain line; driven from a register when `bus_oe`=1, otherwise Z.

Behaviour:
- Reset values (`rst_n`=0 at an edge): state IDLE, `bus_oe`=1, driven line value 0, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0.
- Reset mid-operation: the frame is abandoned and the next cycle drives 0. There is no partial response.
- FSM states: IDLE, START, CMD, CMD_TAIL, GAP, WDATA, WTAIL, RDATA, RTURN, DONE.
- Timing reference: cycle 0 is the acceptance edge; each state below lasts the stated number of cycles, and the line value changes only on rising edges.
- Command frame, common to all operations:
  - START: 1 cycle, line=1.
  - CMD: `CMD_LEN` cycles, command bits MSB first.
  - CMD_TAIL: 1 cycle, line=0.
- Command mapping: OP_RESET→RESET_CMD, OP_WRITE→START_RCV_CMD, OP_UPDATE→UPDATE_CMD, OP_READ→START_SND_CMD.
- GAP: line driven 0 for the op's gap parameter, i.e. RST_GAP, RCV_GAP, UPD_GAP or SND_GAP. A gap of 0 skips the state.
- WRITE:
  - GAP → WDATA: `DATA_LEN` cycles, `req_data` bits MSB first.
  - → WTAIL: 1 cycle, line=0.
  - → DONE.
- RESET and UPDATE: GAP → DONE.
- READ, entered after GAP:
  - RDATA: `bus_oe`=0 for `DATA_LEN` cycles. `data_inout` is sampled at the rising edge ending each cycle and shifted in MSB first.
  - RTURN: 1 cycle, `bus_oe` still 0 (turnaround).
  - → DONE. `bus_oe` returns to 1, driving 0.
- DONE: 1 cycle.
  - For READ, `rsp_data` is updated and `rsp_valid`=1 in this cycle.
  - Then IDLE: `req_ready`=1, `busy`=0.
- Total cycles, acceptance to IDLE:
  - RESET: `CMD_LEN`+3+`RST_GAP`.
  - WRITE: `CMD_LEN`+4+`RCV_GAP`+`DATA_LEN`.
  - UPDATE: `CMD_LEN`+3+`UPD_GAP`.
  - READ: `CMD_LEN`+4+`SND_GAP`+`DATA_LEN`.
- Request port rules:
  - `req_valid` while busy is ignored; no queueing.
  - `req_op`/`req_data` changing after acceptance have no effect.
  - Back-to-back requests: a request held valid is accepted on the first IDLE cycle, giving a minimum of one idle line cycle between frames.
- Bus safety: the line is never driven while `bus_oe`=0. `bus_oe` changes only at RDATA entry and DONE entry.
- Width rules: shift and bit counters are sized `$clog2(max(DATA_LEN,CMD_LEN,gaps)+1)` and saturate-free. Counters are reloaded at each state entry and count down to 0.

Decomposition:
- `` `DATA_LEN ``, `` `CMD_LEN ``, `ctrl_cmd_t` and the command constants stay in `includes.svh`, shared with `serial_ctrl`.
- New package `ser_ctrl_master_pkg` holds `master_op_t`, the state enum `mst_state_t`, and the gap defaults.
- One sub-module, `ser_shift_reg`: a parallel-load, MSB-first shift register with serial in/out. It is instantiated once and shared between the command, write and read phases.

Test Plan:
- Reset: hold `rst_n`=0 for 2 cycles, then release → `req_ready`=1, `busy`=0, `bus_oe`=1, line 0, `rsp_data`=0.
- RESET op → line shows 1, RESET_CMD bits MSB first, then 0 for 4 cycles → `busy` drops after `CMD_LEN`+6 cycles. A `serial_ctrl` DUT attached to the line reaches RESET_ST.
- WRITE 8'h48 → line: 1, START_RCV_CMD bits, 0, 0, then 0,1,0,0,1,0,0,0, then 0.
  - Follow with UPDATE → slave reaches UPDATE_ST with output 8'h48.
- READ from a slave loaded with 8'h48:
  - `bus_oe` falls exactly `CMD_LEN`+4 cycles after acceptance.
  - `rsp_valid` is a single pulse with `rsp_data`=8'h48.
  - No X/contention is seen on `data_inout`.
- Reset mid-WRITE (after bit 3 of the data) → next cycle line 0, `bus_oe`=1, state IDLE, no `rsp_valid`. A following RESET op completes normally.
- `req_valid` held high continuously alternating WRITE/READ (8'hA5) → each accepted only in IDLE, ops do not overlap, and the read returns 8'hA5.
